// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, instruction size and opcodes.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;

    // Opcodes whose decode produces the jump / branch_taken controls.
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000100;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection for a consumed instruction: jump > taken branch > pc+4.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int unsigned AW = 32
) (
    input  logic [AW-1:0] instr_pc_i,
    input  logic          jump_i,
    input  logic [25:0]   jump_index_i,
    input  logic          branch_taken_i,
    input  logic [15:0]   branch_imm_i,
    output logic [AW-1:0] next_pc_o,
    output logic          misaligned_o
);

    logic [AW-1:0] pc4;
    logic [AW-1:0] br_off;
    logic [AW-1:0] jump_tgt;
    logic [AW-1:0] br_tgt;

    assign pc4      = instr_pc_i + AW'(INSTR_BYTES);
    assign br_off   = {{(AW-18){branch_imm_i[15]}}, branch_imm_i, 2'b00};
    // Jump keeps the region bits of the sequential successor, not of instr_pc.
    assign jump_tgt = {pc4[AW-1:28], jump_index_i, 2'b00};
    assign br_tgt   = pc4 + br_off;

    always_comb begin
        next_pc_o = pc4;
        if (jump_i) begin
            next_pc_o = jump_tgt;
        end else if (branch_taken_i) begin
            next_pc_o = br_tgt;
        end
    end

    assign misaligned_o = |next_pc_o[1:0];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the PC, fetches over req/ack, holds the word for the datapath.
// Latency: one cycle from ack to instr_valid; 2 cycles/instr with zero-wait memory.
// Backpressure: holds instr and issues no new request while instr_ready is low.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned        IMEM_AW  = 32,
    parameter logic [IMEM_AW-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        instr,
    output logic [IMEM_AW-1:0] instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               jump,
    input  logic [25:0]        jump_index,
    input  logic               branch_taken,
    input  logic [15:0]        branch_imm,
    output logic               fetch_err
);

    fetch_state_t       state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_d;
    logic [31:0]        instr_q, instr_d;
    logic [IMEM_AW-1:0] instr_pc_q, instr_pc_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;

    logic [IMEM_AW-1:0] next_pc;
    logic               next_misaligned;

    next_pc_calc #(
        .AW (IMEM_AW)
    ) u_next_pc (
        .instr_pc_i     (instr_pc_q),
        .jump_i         (jump),
        .jump_index_i   (jump_index),
        .branch_taken_i (branch_taken),
        .branch_imm_i   (branch_imm),
        .next_pc_o      (next_pc),
        .misaligned_o   (next_misaligned)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        err_d      = err_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                // pc_q is untouched here, so the address is stable across wait states.
                if (imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    valid_d = 1'b0;
                    pc_d    = next_pc;
                    if (next_misaligned) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: chained fetch/consume vectors plus reset and misalignment sequences.
module tb_ifetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, RESET_PC = 0
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        jump;
    logic [25:0] jump_index;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        fetch_err;

    // Second instance, RESET_PC = 2
    logic        rst_m;
    logic        imem_req_m;
    logic [31:0] imem_addr_m;
    logic        imem_ack_m;
    logic [31:0] imem_rdata_m;
    logic [31:0] instr_m;
    logic [31:0] instr_pc_m;
    logic        instr_valid_m;
    logic        instr_ready_m;
    logic        fetch_err_m;
    logic        zero1_m;
    logic [25:0] zero26_m;
    logic [15:0] zero16_m;

    ifetch_unit #(.IMEM_AW(32), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .jump         (jump),
        .jump_index   (jump_index),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .fetch_err    (fetch_err)
    );

    ifetch_unit #(.IMEM_AW(32), .RESET_PC(32'h0000_0002)) dut_m (
        .clk          (clk),
        .rst          (rst_m),
        .imem_req     (imem_req_m),
        .imem_addr    (imem_addr_m),
        .imem_ack     (imem_ack_m),
        .imem_rdata   (imem_rdata_m),
        .instr        (instr_m),
        .instr_pc     (instr_pc_m),
        .instr_valid  (instr_valid_m),
        .instr_ready  (instr_ready_m),
        .jump         (zero1_m),
        .jump_index   (zero26_m),
        .branch_taken (zero1_m),
        .branch_imm   (zero16_m),
        .fetch_err    (fetch_err_m)
    );

    typedef struct {
        logic [31:0] addr;
        int          lat;
        int          rdy_dly;
        logic        jmp;
        logic [25:0] jidx;
        logic        br;
        logic [15:0] imm;
        logic [31:0] next;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_req();
        for (int k = 0; k < 20; k++) begin
            if (imem_req === 1'b1) break;
            @(negedge clk);
        end
        chk("req_timeout", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic drop_ctl();
        jump         = 1'b0;
        jump_index   = '0;
        branch_taken = 1'b0;
        branch_imm   = '0;
    endtask

    task automatic run_vec(input vec_t v);
        wait_req();
        chk("fetch_addr", imem_addr, v.addr);
        for (int k = 0; k < v.lat; k++) begin
            imem_ack     = 1'b0;
            instr_ready  = 1'b1;
            jump         = 1'b1;
            branch_taken = 1'b1;
            @(negedge clk);
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, v.addr);
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
        end
        instr_ready = 1'b0;
        drop_ctl();
        imem_ack   = 1'b1;
        imem_rdata = mem_word(v.addr);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("ack_valid", {31'd0, instr_valid}, 32'd1);
        chk("ack_instr", instr, mem_word(v.addr));
        chk("ack_instr_pc", instr_pc, v.addr);
        chk("ack_req_low", {31'd0, imem_req}, 32'd0);
        for (int k = 0; k < v.rdy_dly; k++) begin
            instr_ready  = 1'b0;
            imem_ack     = 1'b1;
            imem_rdata   = 32'hBAD0_BAD0;
            jump         = 1'b1;
            jump_index   = '1;
            branch_taken = 1'b1;
            branch_imm   = 16'h4000;
            @(negedge clk);
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
            chk("hold_instr", instr, mem_word(v.addr));
            chk("hold_instr_pc", instr_pc, v.addr);
            chk("hold_req_low", {31'd0, imem_req}, 32'd0);
        end
        imem_ack     = 1'b0;
        instr_ready  = 1'b1;
        jump         = v.jmp;
        jump_index   = v.jidx;
        branch_taken = v.br;
        branch_imm   = v.imm;
        @(negedge clk);
        instr_ready = 1'b0;
        drop_ctl();
        chk("next_req", {31'd0, imem_req}, 32'd1);
        chk("next_addr", imem_addr, v.next);
        chk("next_valid_low", {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        //            addr          lat rdy jmp jidx          br    imm       next
        vecs[0]  = '{32'h0000_0000, 0, 0, 1'b0, 26'h0,       1'b0, 16'h0000, 32'h0000_0004};
        vecs[1]  = '{32'h0000_0004, 0, 0, 1'b0, 26'h0,       1'b0, 16'h0000, 32'h0000_0008};
        vecs[2]  = '{32'h0000_0008, 3, 4, 1'b1, 26'h0000008, 1'b0, 16'h0000, 32'h0000_0020};
        vecs[3]  = '{32'h0000_0020, 0, 0, 1'b0, 26'h0,       1'b1, 16'hFFFC, 32'h0000_0014};
        vecs[4]  = '{32'h0000_0014, 1, 0, 1'b1, 26'h0000008, 1'b0, 16'h0000, 32'h0000_0020};
        vecs[5]  = '{32'h0000_0020, 0, 2, 1'b0, 26'h0,       1'b1, 16'h0003, 32'h0000_0030};
        vecs[6]  = '{32'h0000_0030, 0, 0, 1'b1, 26'h3FFFFFF, 1'b0, 16'h0000, 32'h0FFF_FFFC};
        vecs[7]  = '{32'h0FFF_FFFC, 2, 0, 1'b0, 26'h0,       1'b0, 16'h0000, 32'h1000_0000};
        vecs[8]  = '{32'h1000_0000, 0, 1, 1'b1, 26'h0000040, 1'b1, 16'h0007, 32'h1000_0100};
        vecs[9]  = '{32'h1000_0100, 0, 0, 1'b0, 26'h0,       1'b1, 16'h8000, 32'h0FFE_0104};
        vecs[10] = '{32'h0FFE_0104, 0, 0, 1'b1, 26'h0,       1'b0, 16'h0000, 32'h0000_0000};
        vecs[11] = '{32'h0000_0000, 0, 0, 1'b0, 26'h0,       1'b1, 16'hFFFE, 32'hFFFF_FFFC};
        vecs[12] = '{32'hFFFF_FFFC, 0, 0, 1'b0, 26'h0,       1'b0, 16'h0000, 32'h0000_0000};
        vecs[13] = '{32'h0000_0000, 0, 0, 1'b0, 26'h0,       1'b0, 16'h1234, 32'h0000_0004};

        rst = 1'b1;  rst_m = 1'b1;
        imem_ack = 1'b0;  imem_rdata = '0;  instr_ready = 1'b0;
        drop_ctl();
        imem_ack_m = 1'b0;  imem_rdata_m = '0;  instr_ready_m = 1'b0;
        zero1_m = 1'b0;  zero26_m = '0;  zero16_m = '0;

        #2 rst = 1'b0;  rst_m = 1'b0;
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        chk("rst_m_addr", imem_addr_m, 32'h2);
        chk("rst_m_req", {31'd0, imem_req_m}, 32'd0);

        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("first_req", {31'd0, imem_req}, 32'd1);

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);
        chk("no_err_main", {31'd0, fetch_err}, 32'd0);

        // Reset while a request to 0x4 is outstanding, ack held through reset release.
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("mid_rst_instr", instr, 32'h0);
        chk("mid_rst_instr_pc", instr_pc, 32'h0);
        @(negedge clk);
        chk("in_rst_valid", {31'd0, instr_valid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_addr", imem_addr, 32'h0);
        chk("stale_ack_valid", {31'd0, instr_valid}, 32'd0);
        chk("stale_ack_instr", instr, 32'h0);
        imem_ack = 1'b0;
        @(negedge clk);
        chk("post_rst_hold_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_hold_valid", {31'd0, instr_valid}, 32'd0);
        run_vec(vecs[0]);

        // Misaligned RESET_PC instance.
        rst_m = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (imem_req_m === 1'b1) break;
            @(negedge clk);
        end
        chk("m_req_timeout", {31'd0, imem_req_m}, 32'd1);
        chk("m_fetch_addr", imem_addr_m, 32'h2);
        imem_ack_m   = 1'b1;
        imem_rdata_m = 32'h1234_5678;
        @(negedge clk);
        imem_ack_m = 1'b0;
        chk("m_valid", {31'd0, instr_valid_m}, 32'd1);
        chk("m_instr", instr_m, 32'h1234_5678);
        chk("m_instr_pc", instr_pc_m, 32'h2);
        chk("m_err_before", {31'd0, fetch_err_m}, 32'd0);
        instr_ready_m = 1'b1;
        @(negedge clk);
        chk("m_err", {31'd0, fetch_err_m}, 32'd1);
        chk("m_halt_req", {31'd0, imem_req_m}, 32'd0);
        chk("m_halt_valid", {31'd0, instr_valid_m}, 32'd0);
        imem_ack_m = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("m_halt_req_stay", {31'd0, imem_req_m}, 32'd0);
            chk("m_halt_err_stay", {31'd0, fetch_err_m}, 32'd1);
            chk("m_halt_valid_stay", {31'd0, instr_valid_m}, 32'd0);
        end
        imem_ack_m    = 1'b0;
        instr_ready_m = 1'b0;
        rst_m = 1'b0;
        #1;
        chk("m_rst_err", {31'd0, fetch_err_m}, 32'd0);
        chk("m_rst_addr", imem_addr_m, 32'h2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage placed directly upstream of the single-cycle datapath.
- Owns the program counter and fetches from instruction memory over a req/ack handshake, so the memory latency can vary.
- Presents each instruction to the datapath with a valid/ready handshake.
- Applies branch and jump redirects when the datapath consumes an instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address
IMEM_AW, 32, width of the instruction address bus (PC width)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
imem_req  output  1  fetch request to instruction memory
imem_addr  output  IMEM_AW  byte address of the fetch
imem_ack  input  1  memory returns data this cycle
imem_rdata  input  32  instruction word, valid when imem_ack=1
instr  output  32  held instruction word
instr_pc  output  IMEM_AW  address of instr
instr_valid  output  1  instr/instr_pc valid
instr_ready  input  1  datapath consumes instr this cycle
jump  input  1  consumed instruction is a jump
jump_index  input  26  instr[25:0] of the jump
branch_taken  input  1  consumed instruction is a branch and zero=1
branch_imm  input  16  instr[15:0] of the branch
fetch_err  output  1  sticky: misaligned redirect target

Behaviour:
- Reset (rst=0, asynchronous):
  - state=S_IDLE, pc=RESET_PC.
  - imem_req=0, imem_addr=RESET_PC.
  - instr=0, instr_pc=0, instr_valid=0, fetch_err=0.
  - Asserting reset mid-fetch abandons the request. Any imem_ack arriving after reset is ignored.
- FSM states: S_IDLE, S_REQ, S_HOLD, S_HALT.
- S_IDLE: on the first rising edge with rst=1, go to S_REQ.
- S_REQ:
  - imem_req=1 and imem_addr=pc. imem_addr must stay stable until ack.
  - On imem_ack=1: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, go to S_HOLD.
  - A zero-wait memory (ack in the same cycle as req) is legal.
  - The request is held indefinitely while imem_ack=0.
- S_HOLD:
  - imem_req=0; instr and instr_pc are held stable.
  - The unit waits while instr_ready=0.
  - On instr_ready=1: instr_valid<=0, pc<=next_pc, go to S_REQ.
  - If next_pc[1:0]!=0, go to S_HALT instead and set fetch_err<=1.
- S_HALT: imem_req=0 and instr_valid=0 until reset. fetch_err stays at 1.
- next_pc is evaluated only in the S_HOLD consume cycle. jump and branch_* are ignored at all other times.
- Redirect priority, highest first:
  - jump=1: next_pc={pc4[31:28], jump_index, 2'b00}, where pc4=instr_pc+4.
  - branch_taken=1: next_pc=pc4 + (sign_extend(branch_imm) << 2).
  - Otherwise: next_pc=pc4.
- Arithmetic is modulo 2^32. pc4 at 0xFFFF_FFFC wraps to 0x0000_0000, and a negative offset below 0 wraps.
- jump=1 together with branch_taken=1: the jump wins.
- Misalignment can only come from RESET_PC[1:0]!=0; jump and branch targets are word-aligned by construction. A misaligned RESET_PC is fetched anyway. The error check applies only to next_pc.
- Throughput is 2 cycles per instruction with a zero-wait memory and instr_ready held at 1.
- An imem_ack seen outside S_REQ is ignored.

Decomposition:
- Shared package (cpu_pkg), holds:
  - the fetch state enum;
  - INSTR_BYTES=4;
  - opcode constants for J and BEQ, shared with control_sig.
- One combinational sub-module: next_pc_calc.
  - Inputs: instr_pc, jump, jump_index, branch_taken, branch_imm.
  - Outputs: next_pc, misaligned.
  - Kept separate so it can be unit-tested against the branch and jump formulas.

Test Plan:
- Reset and sequential fetch: zero-wait memory, instr_ready=1, RESET_PC=0 -> imem_addr sequence 0x0, 0x4, 0x8. instr_valid pulses every 2nd cycle with instr_pc matching.
- Wait states and backpressure: ack delayed 3 cycles, then instr_ready held at 0 for 4 cycles -> imem_addr stable during the wait. instr, instr_pc and instr_valid stay constant until ready. No new req is issued.
- Branch: instr_pc=0x20, branch_taken=1, branch_imm=16'hFFFC -> next imem_addr=0x14. With branch_imm=16'h0003 -> 0x30.
- Jump priority and wrap: instr_pc=0x1000_0000, jump=1, jump_index=26'h0000040, branch_taken=1 -> imem_addr=0x1000_0100. Sequential fetch at instr_pc=0xFFFF_FFFC -> imem_addr=0x0000_0000.
- Reset mid-operation: rst=0 while in S_REQ with ack pending, ack asserted during reset -> outputs take reset values immediately. After release, the first req goes to RESET_PC and the stale ack is not latched.
- Misalignment: RESET_PC=0x2 (separate bench instance), the only way to produce a misaligned next_pc -> fetch at 0x2 completes. On consume, next_pc=0x6, fetch_err=1, imem_req stays 0 until reset.
